// File: rtl/writeback_select_unit.sv
// Writeback-stage selector: picks ALU / load / PC+4 / immediate, extracts and extends
// load data, and issues a one-cycle register-file write pulse; waits on slow loads with a timeout.
module writeback_select_unit #(
    parameter int XLEN    = 32,
    parameter int OFF_W   = 2,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        wb_sel,
    input  logic [XLEN-1:0]   alu_output,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   pc_plus4,
    input  logic [XLEN-1:0]   imm_value,
    input  logic [1:0]        load_size,
    input  logic              load_unsigned,
    input  logic [OFF_W-1:0]  byte_offset,
    input  logic [4:0]        rd_addr,
    input  logic              reg_write,
    output logic [XLEN-1:0]   processor_output,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic              wb_we,
    output logic              stall,
    output logic              mem_err
);

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    state_t            state, state_nxt;
    logic [7:0]        cnt;
    logic              accept, done, abort, latch;
    logic [XLEN-1:0]   done_data;
    logic [4:0]        done_rd;
    logic              done_we;

    // Load fields held while waiting for a multi-cycle memory response
    logic [1:0]        ld_size_p0;
    logic              ld_uns_p0;
    logic [OFF_W-1:0]  ld_off_p0;
    logic [4:0]        ld_rd_p0;
    logic              ld_we_p0;

    function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] d,
                                                input logic [1:0] sz,
                                                input logic uns,
                                                input logic [OFF_W-1:0] off);
        logic [7:0]      b;
        logic [15:0]     h;
        logic [31:0]     w;
        logic            wsel;
        logic [XLEN-1:0] r;
        b    = 8'(d >> {off, 3'b000});
        h    = 16'(d >> {off[OFF_W-1:1], 4'b0000});
        wsel = (XLEN == 64) ? off[OFF_W-1] : 1'b0;
        w    = 32'(d >> {wsel, 5'b00000});
        case (sz)
            2'b00:   r = uns ? XLEN'(b) : XLEN'($signed(b));
            2'b01:   r = uns ? XLEN'(h) : XLEN'($signed(h));
            default: r = uns ? XLEN'(w) : XLEN'($signed(w));
        endcase
        if (sz == 2'b11 && XLEN == 64) r = d;
        return r;
    endfunction

    assign in_ready = (state == IDLE);
    assign stall    = (state == WAIT_MEM);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        abort     = 1'b0;
        latch     = 1'b0;
        done_data = '0;
        done_rd   = ld_rd_p0;
        done_we   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (wb_sel != 2'b00 || mem_rvalid) begin
                        done    = 1'b1;
                        done_rd = rd_addr;
                        done_we = reg_write && (rd_addr != 5'd0);
                        case (wb_sel)
                            2'b01:   done_data = alu_output;
                            2'b10:   done_data = pc_plus4;
                            2'b11:   done_data = imm_value;
                            default: done_data = extract(mem_rdata, load_size, load_unsigned, byte_offset);
                        endcase
                    end else begin
                        latch     = 1'b1;
                        state_nxt = WAIT_MEM;
                    end
                end
            end
            WAIT_MEM: begin
                // A response on the final allowed cycle takes priority over the timeout
                if (mem_rvalid) begin
                    done      = 1'b1;
                    done_we   = ld_we_p0;
                    done_data = extract(mem_rdata, ld_size_p0, ld_uns_p0, ld_off_p0);
                    state_nxt = IDLE;
                end else if (cnt == 8'(TIMEOUT - 1)) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   cnt <= '0;
        else if (latch)            cnt <= '0;
        else if (state == WAIT_MEM) cnt <= cnt + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (latch) begin
            ld_size_p0 <= load_size;
            ld_uns_p0  <= load_unsigned;
            ld_off_p0  <= byte_offset;
            ld_rd_p0   <= rd_addr;
            ld_we_p0   <= reg_write && (rd_addr != 5'd0);
        end
    end

    // Writeback register stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            processor_output <= '0;
            wb_valid         <= 1'b0;
            wb_rd            <= 5'd0;
            wb_we            <= 1'b0;
            mem_err          <= 1'b0;
        end else begin
            wb_valid <= done || abort;
            wb_we    <= done && done_we;
            mem_err  <= abort;
            if (done || abort) wb_rd <= done_rd;
            if (done)       processor_output <= done_data;
            else if (abort) processor_output <= '0;
        end
    end

endmodule

// File: tb/tb_writeback_select_unit.sv
// Scoreboard bench for writeback_select_unit (XLEN=32, TIMEOUT=4).
module tb_writeback_select_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [1:0]  wb_sel;
    logic [31:0] alu_output, mem_rdata, pc_plus4, imm_value;
    logic        mem_rvalid;
    logic [1:0]  load_size;
    logic        load_unsigned;
    logic [1:0]  byte_offset;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic [31:0] processor_output;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_we, stall, mem_err;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_wb  = 0;

    always #5 clk = ~clk;

    writeback_select_unit #(.XLEN(32), .OFF_W(2), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .wb_sel(wb_sel), .alu_output(alu_output), .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid), .pc_plus4(pc_plus4), .imm_value(imm_value),
        .load_size(load_size), .load_unsigned(load_unsigned),
        .byte_offset(byte_offset), .rd_addr(rd_addr), .reg_write(reg_write),
        .processor_output(processor_output), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_we(wb_we), .stall(stall), .mem_err(mem_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] d, input logic [1:0] sz,
                                               input logic uns, input logic [1:0] off);
        logic [31:0] v;
        case (sz)
            2'b00: begin
                v = (d >> (off * 8)) & 32'hFF;
                if (!uns && v[7]) v = v | 32'hFFFF_FF00;
            end
            2'b01: begin
                v = (off[1] ? (d >> 16) : d) & 32'hFFFF;
                if (!uns && v[15]) v = v | 32'hFFFF_0000;
            end
            default: v = d;
        endcase
        return v;
    endfunction

    // Completion monitor: every wb_valid must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && wb_valid) begin
            n_wb++;
            if (exp_q.size() == 0) begin
                check("unexpected_wb_valid", 64'(wb_valid), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wb_data", 64'(processor_output), 64'(e.data));
                check("wb_rd",   64'(wb_rd),   64'(e.rd));
                check("wb_we",   64'(wb_we),   64'(e.we));
                check("mem_err", 64'(mem_err), 64'(e.err));
            end
        end else if (!rst) begin
            if (wb_we || mem_err) check("idle_we_err", {62'd0, wb_we, mem_err}, 64'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] sel, input logic [31:0] val,
                         input logic [1:0] sz, input logic uns, input logic [1:0] off,
                         input logic [4:0] rd, input logic rw, input logic rv,
                         input logic [31:0] rdata, input logic push);
        exp_t e;
        in_valid      = 1'b1;
        wb_sel        = sel;
        alu_output    = (sel == 2'b01) ? val : $urandom;
        pc_plus4      = (sel == 2'b10) ? val : $urandom;
        imm_value     = (sel == 2'b11) ? val : $urandom;
        load_size     = sz;
        load_unsigned = uns;
        byte_offset   = off;
        rd_addr       = rd;
        reg_write     = rw;
        mem_rvalid    = rv;
        mem_rdata     = rdata;
        e.data = (sel == 2'b00) ? model_load(rdata, sz, uns, off) : val;
        e.rd   = rd;
        e.we   = rw && (rd != 5'd0);
        e.err  = 1'b0;
        if (push) exp_q.push_back(e);
        step();
        in_valid   = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
    endtask

    // Spend n cycles in WAIT_MEM; optionally respond on the last of them
    task automatic wait_mem(input int n, input logic respond, input logic [31:0] rdata);
        for (int i = 1; i <= n; i++) begin
            check($sformatf("stall_c%0d", i), 64'(stall), 64'd1);
            check($sformatf("in_ready_c%0d", i), 64'(in_ready), 64'd0);
            if (i == n && respond) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rdata;
            end
            step();
            mem_rvalid = 1'b0;
        end
        check("stall_after", 64'(stall), 64'd0);
        check("in_ready_after", 64'(in_ready), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   wb_before;
        rst = 1'b1; in_valid = 1'b0; wb_sel = 2'b01; alu_output = '0; mem_rdata = '0;
        mem_rvalid = 1'b0; pc_plus4 = '0; imm_value = '0; load_size = 2'b00;
        load_unsigned = 1'b0; byte_offset = '0; rd_addr = '0; reg_write = 1'b0;
        #12;
        check("rst_out",   64'(processor_output), 64'd0);
        check("rst_valid", 64'(wb_valid), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_err",   64'(mem_err), 64'd0);
        check("rst_we",    64'(wb_we), 64'd0);
        step();
        rst = 1'b0;
        step();
        check("rdy_after_rst", 64'(in_ready), 64'd1);

        // ALU pass-through, then wb_valid drops
        issue(2'b01, 32'h1234_5678, 2'b00, 1'b0, 2'd0, 5'd5, 1'b1, 1'b0, 32'h0, 1'b1);
        check("alu_out", 64'(processor_output), 64'h1234_5678);
        step();
        check("alu_valid_drop", 64'(wb_valid), 64'd0);
        check("alu_hold", 64'(processor_output), 64'h1234_5678);

        // Signed / unsigned byte loads after a 3-cycle wait
        issue(2'b00, 32'h0, 2'b00, 1'b0, 2'd2, 5'd7, 1'b1, 1'b0, 32'h0080_0000, 1'b1);
        wait_mem(3, 1'b1, 32'h0080_0000);
        issue(2'b00, 32'h0, 2'b00, 1'b1, 2'd2, 5'd8, 1'b1, 1'b0, 32'h0080_0000, 1'b1);
        wait_mem(3, 1'b1, 32'h0080_0000);
        check("byte_u_out", 64'(processor_output), 64'h0000_0080);

        // Same-cycle responses, various sizes and offsets
        issue(2'b00, 32'h0, 2'b01, 1'b1, 2'd2, 5'd9,  1'b1, 1'b1, 32'hBEEF_0000, 1'b1);
        check("half_nostall", 64'(stall), 64'd0);
        check("half_u_out", 64'(processor_output), 64'h0000_BEEF);
        issue(2'b00, 32'h0, 2'b01, 1'b0, 2'd3, 5'd10, 1'b1, 1'b1, 32'hBEEF_0000, 1'b1);
        issue(2'b00, 32'h0, 2'b01, 1'b0, 2'd0, 5'd11, 1'b1, 1'b1, 32'h1234_8001, 1'b1);
        issue(2'b00, 32'h0, 2'b00, 1'b0, 2'd3, 5'd12, 1'b0, 1'b1, 32'h7F00_00FF, 1'b1);
        issue(2'b00, 32'h0, 2'b00, 1'b1, 2'd0, 5'd13, 1'b1, 1'b1, 32'h7F00_00FF, 1'b1);
        issue(2'b00, 32'h0, 2'b10, 1'b0, 2'd1, 5'd14, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b1);
        issue(2'b00, 32'h0, 2'b11, 1'b0, 2'd0, 5'd15, 1'b1, 1'b1, 32'h8765_4321, 1'b1);
        step();

        // Timeout abort after 4 WAIT cycles
        issue(2'b00, 32'h0, 2'b10, 1'b0, 2'd0, 5'd16, 1'b1, 1'b0, 32'h0, 1'b0);
        e.data = 32'h0; e.rd = 5'd16; e.we = 1'b0; e.err = 1'b1;
        exp_q.push_back(e);
        wait_mem(4, 1'b0, 32'h0);
        check("to_err", 64'(mem_err), 64'd1);
        step();
        check("to_err_pulse", 64'(mem_err), 64'd0);

        // Response on the timeout cycle wins
        issue(2'b00, 32'h0, 2'b10, 1'b0, 2'd0, 5'd17, 1'b1, 1'b0, 32'h5A5A_A5A5, 1'b1);
        wait_mem(4, 1'b1, 32'h5A5A_A5A5);
        check("race_no_err", 64'(mem_err), 64'd0);

        // Stray mem_rvalid in IDLE is ignored
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        step();

        // Back-to-back PC+4 / IMM to x0
        wb_before = n_wb;
        issue(2'b10, 32'h0000_0104, 2'b00, 1'b0, 2'd0, 5'd0, 1'b1, 1'b0, 32'h0, 1'b1);
        issue(2'b11, 32'hABCD_E000, 2'b00, 1'b0, 2'd0, 5'd0, 1'b1, 1'b0, 32'h0, 1'b1);
        check("b2b_valid", 64'(wb_valid), 64'd1);
        issue(2'b10, 32'h0000_0104, 2'b00, 1'b0, 2'd0, 5'd0, 1'b1, 1'b0, 32'h0, 1'b1);
        issue(2'b11, 32'hABCD_E000, 2'b00, 1'b0, 2'd0, 5'd0, 1'b1, 1'b0, 32'h0, 1'b1);
        step();
        check("b2b_count", 64'(n_wb - wb_before), 64'd4);

        // Reset while waiting, then a late response
        issue(2'b00, 32'h0, 2'b10, 1'b0, 2'd0, 5'd20, 1'b1, 1'b0, 32'h0, 1'b0);
        step();
        rst = 1'b1;
        #1;
        check("mid_rst_stall", 64'(stall), 64'd0);
        check("mid_rst_out",   64'(processor_output), 64'd0);
        check("mid_rst_valid", 64'(wb_valid), 64'd0);
        step();
        rst = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        step();
        mem_rvalid = 1'b0;
        step();
        check("mid_rst_ready", 64'(in_ready), 64'd1);

        step();
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/writeback_select_unit.md
Name: writeback_select_unit

Overview:
- Parametrised writeback-stage selector for the RISC-V core.
- Chooses among four sources (ALU result, load data, PC+4, immediate) and performs byte/half/word load extraction with sign or zero extension.
- Registers the selected value and presents a one-cycle writeback pulse to the register file.
- Waits, stalling upstream, for multi-cycle memory responses, with a timeout error path.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
OFF_W, 2, byte-offset width; must equal log2(XLEN/8), so 2 for XLEN=32 and 3 for XLEN=64.
TIMEOUT, 16, maximum cycles spent in WAIT_MEM before an error abort; legal range 1..255.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous active-high reset.
in_valid  input  1  writeback request present.
in_ready  output  1  unit can accept a request (combinational, high only in IDLE).
wb_sel  input  2  source select: 01 ALU, 00 MEM, 10 PC+4, 11 IMM.
alu_output  input  XLEN  ALU result.
mem_rdata  input  XLEN  raw memory read word.
mem_rvalid  input  1  mem_rdata valid this cycle.
pc_plus4  input  XLEN  link value for JAL/JALR.
imm_value  input  XLEN  immediate for LUI.
load_size  input  2  00 byte, 01 half, 10 word (32-bit), 11 double (XLEN=64 only; otherwise treated as word).
load_unsigned  input  1  1 selects zero extension, 0 selects sign extension.
byte_offset  input  OFF_W  low address bits of the load.
rd_addr  input  5  destination register.
reg_write  input  1  instruction writes rd.
processor_output  output  XLEN  registered writeback data.
wb_valid  output  1  one-cycle writeback pulse.
wb_rd  output  5  registered destination.
wb_we  output  1  registered write enable.
stall  output  1  high while in WAIT_MEM.
mem_err  output  1  one-cycle pulse on load timeout.

Behaviour:
- Reset (asynchronous, any state): state IDLE; counter cleared; processor_output, wb_valid, wb_rd, wb_we and mem_err all 0. in_ready is 1 once rst deasserts; stall is 0.
- Accept: a request is accepted when in_valid && in_ready.
- FSM states: IDLE, WAIT_MEM.
- IDLE, accept, wb_sel != 00:
  - Next edge registers processor_output = selected source.
  - wb_valid=1, wb_rd=rd_addr, wb_we = reg_write && (rd_addr != 0).
  - Latency is 1 cycle; back-to-back accepts every cycle give continuous wb_valid.
- IDLE, accept, wb_sel == 00, mem_rvalid=1 in the same cycle: capture extracted data; latency 1; remain in IDLE.
- IDLE, accept, wb_sel == 00, mem_rvalid=0:
  - Latch rd_addr, reg_write, load_size, load_unsigned and byte_offset.
  - Go to WAIT_MEM and clear the counter.
- WAIT_MEM:
  - in_ready=0, stall=1; the counter increments each cycle.
  - On mem_rvalid=1: capture extracted data; wb_valid pulse on the next edge with the latched rd/we; return to IDLE.
  - If the counter reaches TIMEOUT-1 without mem_rvalid: return to IDLE; on that edge processor_output=0, wb_valid=1, wb_we=0, mem_err=1 (one cycle).
  - mem_rvalid arriving on the timeout cycle wins; no error is raised.
- mem_rvalid while in IDLE with no accepted load: ignored.
- wb_valid, wb_we and mem_err are 0 in every cycle that carries no completion.
- Extraction, with off = byte_offset:
  - byte: mem_rdata[8*off +: 8].
  - half: mem_rdata[16*off[OFF_W-1:1] +: 16]; off[0] is ignored (alignment is handled upstream).
  - word: mem_rdata[32*off[OFF_W-1] +: 32] for XLEN=64; the low 32 bits for XLEN=32.
  - double: the full word.
  - The result is extended to XLEN by its MSB, or zero-extended when load_unsigned=1.
- rd_addr = 0: data is still output, but wb_we is forced to 0.
- processor_output holds its last value between pulses.

Test Plan:
- ALU pass-through: wb_sel=01, alu_output=0x1234_5678, rd=5, reg_write=1 -> next cycle processor_output=0x12345678, wb_valid=1, wb_we=1, wb_rd=5; two cycles later wb_valid=0.
- Load byte signed after 3-cycle wait: wb_sel=00, load_size=00, offset=2, mem_rdata=0x0080_0000 with mem_rvalid on the 3rd WAIT cycle -> stall=1 for 3 cycles and in_ready=0; then processor_output=0xFFFF_FF80, wb_valid=1. Repeat with load_unsigned=1 -> 0x0000_0080.
- Half unsigned with same-cycle response: offset=2, mem_rdata=0xBEEF_0000, mem_rvalid=1 at accept -> one-cycle latency, output 0x0000_BEEF, no stall.
- Timeout: TIMEOUT=4, load issued with mem_rvalid never asserted -> after 4 WAIT cycles mem_err=1, wb_valid=1, wb_we=0, output 0; in_ready returns to 1.
- x0 and back-to-back: alternate wb_sel 10 and 11 on consecutive cycles with pc_plus4=0x104, imm=0xABCD_E000, rd=0 -> wb_valid every cycle, outputs 0x104 then 0xABCDE000, wb_we=0 throughout.
- Reset mid-wait: rst asserted in WAIT_MEM -> immediately stall=0 and all outputs 0; a late mem_rvalid after release produces no wb_valid.
